// File: rtl/aes_pkg.sv
// Shared constants and GF(2^8) helpers for the masked AES S-box datapath.
// AES_INV_SBOX_OUT_REG_EN moves the completion count from 4 to 5 (output register stage).
package aes_pkg;

   // Row i of each matrix (bits [8*i +: 8]) selects the input bits XORed into output bit i.
   // X is the polynomial basis used by the DOM inverter, so S2X is the inverse affine map alone.
   localparam logic [63:0] S2X = 64'h5229_944A_2592_49A4;
   localparam logic [63:0] X2A = 64'h8040_2010_0804_0201;

`ifdef AES_INV_SBOX_OUT_REG_EN
   localparam logic [2:0] DONE_CNT = 3'd5;
`else
   localparam logic [2:0] DONE_CNT = 3'd4;
`endif

   // Multiply modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
      end
      return acc;
   endfunction

   // a^(2^k); squaring is linear, so it is applied to each share on its own.
   function automatic logic [7:0] gf_pow2k(input logic [7:0] a, input int k);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < k; i++) r = gf_mul(r, r);
      return r;
   endfunction

endpackage

// File: rtl/aes_dom_inverse_gf2p8.sv
// Two-share DOM inversion x^254 over GF(2^8): one masked multiplication per write-enabled stage,
// following the chain x^3, x^15, x^252, x^254.
module aes_dom_inverse_gf2p8
   import aes_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [3:0]  we_i,
   input  logic [7:0]  a0_i,
   input  logic [7:0]  a1_i,
   input  logic [27:0] prd_i,
   output logic [7:0]  b0_o,
   output logic [7:0]  b1_o
);

   // Cross-domain products are remasked with r before they meet the other domain.
   function automatic logic [15:0] dom_mul(input logic [7:0] x0, input logic [7:0] x1,
                                           input logic [7:0] y0, input logic [7:0] y1,
                                           input logic [7:0] r);
      logic [7:0] c0;
      logic [7:0] c1;
      c0 = gf_mul(x0, y0) ^ (gf_mul(x0, y1) ^ r);
      c1 = gf_mul(x1, y1) ^ (gf_mul(x1, y0) ^ r);
      return {c1, c0};
   endfunction

   logic [1:0][7:0] x_q,    x_d;
   logic [1:0][7:0] p3_q,   p3_d;
   logic [1:0][7:0] p15_q,  p15_d;
   logic [1:0][7:0] p252_q, p252_d;
   logic [1:0][7:0] p254_q, p254_d;

   always_comb begin
      x_d    = x_q;
      p3_d   = p3_q;
      p15_d  = p15_q;
      p252_d = p252_q;
      p254_d = p254_q;
      if (we_i[0]) begin
         x_d  = {a1_i, a0_i};
         p3_d = dom_mul(gf_pow2k(a0_i, 1), gf_pow2k(a1_i, 1), a0_i, a1_i, prd_i[7:0]);
      end
      if (we_i[1])
         p15_d = dom_mul(gf_pow2k(p3_q[0], 2), gf_pow2k(p3_q[1], 2), p3_q[0], p3_q[1], prd_i[15:8]);
      if (we_i[2])
         p252_d = dom_mul(gf_pow2k(p15_q[0], 4), gf_pow2k(p15_q[1], 4),
                          gf_pow2k(p3_q[0], 2), gf_pow2k(p3_q[1], 2), prd_i[23:16]);
      if (we_i[3])
         p254_d = dom_mul(p252_q[0], p252_q[1], gf_pow2k(x_q[0], 1), gf_pow2k(x_q[1], 1),
                          prd_i[27:20]);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q    <= '0;
         p3_q   <= '0;
         p15_q  <= '0;
         p252_q <= '0;
         p254_q <= '0;
      end else begin
         x_q    <= x_d;
         p3_q   <= p3_d;
         p15_q  <= p15_d;
         p252_q <= p252_d;
         p254_q <= p254_d;
      end
   end

   assign b0_o = p254_q[0];
   assign b1_o = p254_q[1];

endmodule

// File: rtl/aes_inv_sbox_dom.sv
// First-order DOM-masked AES inverse S-box with an en/req/ack completion handshake.
// Define AES_INV_SBOX_OUT_REG_EN to register data_o/mask0_o (one extra stage of latency).
module aes_inv_sbox_dom
   import aes_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   output logic        out_req_o,
   input  logic        out_ack_i,
   input  logic [7:0]  data_i,
   input  logic [7:0]  mask0_i,
   input  logic [27:0] prd_i,
   output logic [7:0]  data_o,
   output logic [7:0]  mask0_o
);

   logic [2:0] count_q, count_d;
   logic [3:0] we;
   logic [7:0] data_c;
   logic [7:0] in0_x, in1_x;
   logic [7:0] inv0_x, inv1_x;
   logic [7:0] out0_a, out1_a;

   // The 0x63 constant is removed on the data share only, keeping the mask share linear.
   assign data_c = data_i ^ 8'h63;

   always_comb begin
      in0_x = 8'h00;
      in1_x = 8'h00;
      for (int i = 0; i < 8; i++) begin
         in0_x[i] = ^(data_c  & S2X[8*i +: 8]);
         in1_x[i] = ^(mask0_i & S2X[8*i +: 8]);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_we
         assign we[gi] = en_i & (count_q == 3'(gi));
      end
   endgenerate

   aes_dom_inverse_gf2p8 u_inverse (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .we_i   (we),
      .a0_i   (in0_x),
      .a1_i   (in1_x),
      .prd_i  (prd_i),
      .b0_o   (inv0_x),
      .b1_o   (inv1_x)
   );

   always_comb begin
      out0_a = 8'h00;
      out1_a = 8'h00;
      for (int i = 0; i < 8; i++) begin
         out0_a[i] = ^(inv0_x & X2A[8*i +: 8]);
         out1_a[i] = ^(inv1_x & X2A[8*i +: 8]);
      end
   end

   assign out_req_o = en_i & (count_q == DONE_CNT);

   always_comb begin
      count_d = count_q;
      if (out_req_o && out_ack_i)
         count_d = 3'd0;
      else if (en_i && (count_q != DONE_CNT))
         count_d = count_q + 3'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count_q <= 3'd0;
      else         count_q <= count_d;
   end

`ifdef AES_INV_SBOX_OUT_REG_EN
   logic [7:0] out_data_q, out_data_d;
   logic [7:0] out_mask_q, out_mask_d;

   always_comb begin
      out_data_d = out_data_q;
      out_mask_d = out_mask_q;
      if (en_i && (count_q == 3'd4)) begin
         out_data_d = out0_a;
         out_mask_d = out1_a;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_data_q <= 8'h00;
         out_mask_q <= 8'h00;
      end else begin
         out_data_q <= out_data_d;
         out_mask_q <= out_mask_d;
      end
   end

   assign data_o  = out_data_q;
   assign mask0_o = out_mask_q;
`else
   assign data_o  = out0_a;
   assign mask0_o = out1_a;
`endif

endmodule

// File: tb/tb_aes_inv_sbox_dom.sv
// Self-checking bench for aes_inv_sbox_dom against an InvSbox table built from field arithmetic.
// Expected latency follows AES_INV_SBOX_OUT_REG_EN when it is defined for the build.
module tb_aes_inv_sbox_dom;

`ifdef AES_INV_SBOX_OUT_REG_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 4;
`endif

   logic        clk_i;
   logic        rst_ni;
   logic        en_i;
   logic        out_req_o;
   logic        out_ack_i;
   logic [7:0]  data_i;
   logic [7:0]  mask0_i;
   logic [27:0] prd_i;
   logic [7:0]  data_o;
   logic [7:0]  mask0_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] inv_tbl [256];

   aes_inv_sbox_dom dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (en_i),
      .out_req_o (out_req_o),
      .out_ack_i (out_ack_i),
      .data_i    (data_i),
      .mask0_i   (mask0_i),
      .prd_i     (prd_i),
      .data_o    (data_o),
      .mask0_o   (mask0_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Fresh randomness every cycle, whether or not the DUT consumes it.
   initial begin
      prd_i = 28'h0;
      forever begin
         @(negedge clk_i);
         prd_i = 28'($urandom);
      end
   end

   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [15:0] w;
      w = {x, x} << n;
      return w[15:8];
   endfunction

   // Forward S-box from its definition (brute-force inverse + affine), then invert the table.
   task automatic build_model();
      logic [7:0] inv;
      logic [7:0] s;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (ref_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         inv_tbl[s] = 8'(a);
      end
   endtask

   // One full evaluation with same-cycle ack; leaves en_i low afterwards.
   task automatic run_eval(input logic [7:0] t, input logic [7:0] m,
                           output logic [7:0] res, output int cyc);
      data_i  = t ^ m;
      mask0_i = m;
      en_i    = 1'b1;
      cyc     = 0;
      do begin
         @(negedge clk_i);
         cyc++;
      end while (!out_req_o && cyc < 40);
      res = data_o ^ mask0_o;
      if (!out_req_o) begin
         n_checks++;
         n_fail++;
         $display("FAIL eval_timeout in=%02h: out_req_o never rose within %0d cycles", t, cyc);
      end
      out_ack_i = 1'b1;
      @(negedge clk_i);
      out_ack_i = 1'b0;
      en_i      = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      n_checks++;
      if (out_req_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_req: got %b, want 0", out_req_o);
      end
      n_checks++;
      if (data_o !== 8'h00) begin
         n_fail++; $display("FAIL reset_data: got %02h, want 00", data_o);
      end
      n_checks++;
      if (mask0_o !== 8'h00) begin
         n_fail++; $display("FAIL reset_mask: got %02h, want 00", mask0_o);
      end
      rst_ni = 1'b1;
      @(negedge clk_i);
      $display("reset: req=%b data=%02h mask=%02h", out_req_o, data_o, mask0_o);
   endtask

   task automatic test_kat();
      logic [7:0] kin  [4];
      logic [7:0] kexp [4];
      logic [7:0] r;
      int c;
      kin  = '{8'h63, 8'h7C, 8'h00, 8'h16};
      kexp = '{8'h00, 8'h01, 8'h52, 8'hFF};
      for (int i = 0; i < 4; i++) begin
         run_eval(kin[i], 8'h00, r, c);
         n_checks++;
         if (r !== kexp[i]) begin
            n_fail++; $display("FAIL kat_value in=%02h: got %02h, want %02h", kin[i], r, kexp[i]);
         end else $display("kat in=%02h out=%02h", kin[i], r);
         n_checks++;
         if (c != LAT) begin
            n_fail++; $display("FAIL kat_latency in=%02h: got %0d, want %0d", kin[i], c, LAT);
         end
      end
   endtask

   task automatic test_masked_exhaustive();
      logic [7:0] r;
      logic [7:0] m;
      int c;
      for (int t = 0; t < 256; t++) begin
         m = 8'($urandom);
         run_eval(8'(t), m, r, c);
         n_checks++;
         if (r !== inv_tbl[t]) begin
            n_fail++; $display("FAIL masked in=%02h mask=%02h: got %02h, want %02h", t, m, r, inv_tbl[t]);
         end else $display("masked in=%02h mask=%02h out=%02h", t, m, r);
      end
      for (int k = 0; k < 6; k++) begin
         m = (k == 0) ? 8'hFF : 8'($urandom);
         run_eval(8'hED, m, r, c);
         n_checks++;
         if (r !== 8'h53) begin
            n_fail++; $display("FAIL sweep_ed mask=%02h: got %02h, want 53", m, r);
         end else $display("sweep_ed mask=%02h out=%02h", m, r);
      end
   endtask

   task automatic test_stall();
      logic [7:0] t, m, d0, r;
      int c;
      t = 8'($urandom);
      m = 8'($urandom);
      data_i = t ^ m; mask0_i = m; en_i = 1'b1;
      c = 0;
      do begin @(negedge clk_i); c++; end while (!out_req_o && c < 40);
      n_checks++;
      if (c != LAT) begin
         n_fail++; $display("FAIL stall_latency: got %0d, want %0d", c, LAT);
      end
      d0 = data_o;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         n_checks++;
         if (out_req_o !== 1'b1 || (data_o ^ mask0_o) !== inv_tbl[t] || data_o !== d0) begin
            n_fail++;
            $display("FAIL stall_hold cyc=%0d: req=%b out=%02h data=%02h, want req=1 out=%02h data=%02h",
                     i, out_req_o, data_o ^ mask0_o, data_o, inv_tbl[t], d0);
         end
      end
      out_ack_i = 1'b1;
      @(negedge clk_i);
      out_ack_i = 1'b0;
      n_checks++;
      if (out_req_o !== 1'b0) begin
         n_fail++; $display("FAIL stall_after_ack: req got %b, want 0", out_req_o);
      end
      $display("stall in=%02h held 10 cycles, released", t);
      // Back-to-back: en_i stays high and the next evaluation starts from count 0.
      t = 8'($urandom);
      run_eval(t, 8'($urandom), r, c);
      n_checks++;
      if (c != LAT || r !== inv_tbl[t]) begin
         n_fail++; $display("FAIL back_to_back in=%02h: got %02h/%0d, want %02h/%0d", t, r, c, inv_tbl[t], LAT);
      end else $display("back_to_back in=%02h out=%02h", t, r);
   endtask

   task automatic test_en_gap();
      logic [7:0] t, m;
      int c;
      t = 8'($urandom);
      m = 8'($urandom);
      data_i = t ^ m; mask0_i = m; en_i = 1'b1;
      @(negedge clk_i);
      en_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         n_checks++;
         if (out_req_o !== 1'b0) begin
            n_fail++; $display("FAIL gap_req_low cyc=%0d: got %b, want 0", i, out_req_o);
         end
      end
      en_i = 1'b1;
      c = 4;
      do begin @(negedge clk_i); c++; end while (!out_req_o && c < 40);
      n_checks++;
      if (c != LAT + 3) begin
         n_fail++; $display("FAIL gap_latency: got %0d, want %0d", c, LAT + 3);
      end
      n_checks++;
      if ((data_o ^ mask0_o) !== inv_tbl[t]) begin
         n_fail++; $display("FAIL gap_value in=%02h: got %02h, want %02h", t, data_o ^ mask0_o, inv_tbl[t]);
      end
      // Drop en_i while req is up, and offer an ack that must be ignored.
      en_i = 1'b0;
      #1;
      n_checks++;
      if (out_req_o !== 1'b0) begin
         n_fail++; $display("FAIL req_drop_with_en: got %b, want 0", out_req_o);
      end
      out_ack_i = 1'b1;
      @(negedge clk_i);
      out_ack_i = 1'b0;
      en_i = 1'b1;
      #1;
      n_checks++;
      if (out_req_o !== 1'b1 || (data_o ^ mask0_o) !== inv_tbl[t]) begin
         n_fail++; $display("FAIL req_return: req=%b out=%02h, want req=1 out=%02h",
                            out_req_o, data_o ^ mask0_o, inv_tbl[t]);
      end
      @(negedge clk_i);
      out_ack_i = 1'b1;
      @(negedge clk_i);
      out_ack_i = 1'b0;
      en_i = 1'b0;
      $display("en_gap in=%02h latency=%0d", t, c);
   endtask

   task automatic test_reset_mid();
      logic [7:0] r;
      int c;
      data_i = 8'h5A; mask0_i = 8'h3C; en_i = 1'b1;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      n_checks++;
      if (out_req_o !== 1'b0 || data_o !== 8'h00 || mask0_o !== 8'h00) begin
         n_fail++; $display("FAIL reset_mid: req=%b data=%02h mask=%02h, want 0/00/00",
                            out_req_o, data_o, mask0_o);
      end
      en_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      run_eval(8'h7C, 8'($urandom), r, c);
      n_checks++;
      if (r !== 8'h01 || c != LAT) begin
         n_fail++; $display("FAIL reset_restart: got %02h/%0d, want 01/%0d", r, c, LAT);
      end else $display("reset_restart in=7c out=%02h", r);
   endtask

   initial begin
      rst_ni    = 1'b0;
      en_i      = 1'b0;
      out_ack_i = 1'b0;
      data_i    = 8'h00;
      mask0_i   = 8'h00;
      build_model();
      test_reset();
      test_kat();
      test_masked_exhaustive();
      test_stall();
      test_en_gap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
